// File: rtl/lsu_if.sv
// Memory-side bus between the load/store unit and a single-word data memory.
// The master is the LSU. The slave is the memory that answers with mem_ack and mem_rdata.
interface lsu_if #(
    parameter int D_WIDTH = 32
);
    logic               mem_req;
    logic               mem_we;
    logic [D_WIDTH-1:0] mem_addr;
    logic [3:0]         mem_be;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] mem_rdata;
    logic               mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one access at a time, with alignment and funct3 checks, lane steering,
// and load extension. A REQ phase that waits too long for mem_ack is bounded by a timeout.
//
// state | meaning
// IDLE  | waiting for start; new requests are decoded here
// REQ   | bus request held stable until mem_ack or timeout
// DONE  | one-cycle done pulse with result and fault code
module lsu #(
    parameter int D_WIDTH = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               memwrite,
    input  logic [2:0]         funct3,
    input  logic [D_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] rdata_out,
    output logic [1:0]         fault,
    lsu_if.master              bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_TMO   = 2'b10;
    localparam logic [1:0] FLT_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [D_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]         fault_q, fault_d;

    logic               in_illegal;
    logic               in_misalign;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [D_WIDTH-1:0] ld_ext;
    logic [3:0]         be_v;
    logic [D_WIDTH-1:0] wd_v;

    // Checks on the incoming request. They are only used while IDLE.
    always_comb begin
        in_illegal = 1'b0;
        if (memwrite) begin
            in_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        end else begin
            in_illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        end
        in_misalign = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            in_misalign = addr[0];
        end else if (funct3[1:0] == 2'b10) begin
            in_misalign = (addr[1:0] != 2'b00);
        end
    end

    // Load extraction from the returned word, based on the registered request.
    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'b00:   ld_byte = bus.mem_rdata[7:0];
            2'b01:   ld_byte = bus.mem_rdata[15:8];
            2'b10:   ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_ext  = '0;
        case (f3_q)
            3'b000:  ld_ext = {{(D_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(D_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(D_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(D_WIDTH-16){1'b0}}, ld_half};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    // Byte enables and store lane replication.
    always_comb begin
        be_v = 4'b1111;
        wd_v = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                be_v = 4'b0001 << addr_q[1:0];
                wd_v = D_WIDTH'({4{wdata_q[7:0]}});
            end
            2'b01: begin
                be_v = 4'b0011 << addr_q[1:0];
                wd_v = D_WIDTH'({2{wdata_q[15:0]}});
            end
            default: begin
                be_v = 4'b1111;
                wd_v = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = '0;
        fault_d = FLT_OK;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (in_illegal) begin
                        state_d = DONE;
                        fault_d = FLT_ILL;
                    end else if (in_misalign) begin
                        state_d = DONE;
                        fault_d = FLT_ALIGN;
                    end else begin
                        state_d = REQ;
                        we_d    = memwrite;
                        f3_d    = funct3;
                        addr_d  = addr;
                        wdata_d = wdata;
                    end
                end
            end
            REQ: begin
                // An ack always wins, even on the cycle that would otherwise time out.
                if (bus.mem_ack) begin
                    state_d = DONE;
                    rdata_d = we_q ? '0 : ld_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    fault_d = FLT_TMO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= FLT_OK;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign rdata_out     = rdata_q;
    assign fault         = fault_q;
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = (state_q == REQ) && we_q;
    assign bus.mem_be    = (state_q == REQ) ? be_v : 4'b0000;
    assign bus.mem_addr  = {addr_q[D_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata = wd_v;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table applied in a loop, plus hand-written sequences
// for reset, reset in the middle of REQ, and back-to-back starts.
module tb_lsu;

    localparam int DW = 32;
    localparam int TO = 8;
    localparam int NEVER = 255;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          memwrite;
    logic [2:0]    funct3;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata_out;
    logic [1:0]    fault;

    lsu_if #(.D_WIDTH(DW)) bus ();

    lsu #(.D_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .memwrite  (memwrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata_out (rdata_out),
        .fault     (fault),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          dly;
        logic        chk_wd;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  flt;
        int          lat;
        int          reqs;
    } vec_t;

    vec_t vecs[15];
    int   total;
    int   bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  lat;
        int  reqs;
        bit  got;
        lat  = 0;
        reqs = 0;
        got  = 1'b0;
        @(negedge clk);
        memwrite          = v.we;
        funct3            = v.f3;
        addr              = v.addr;
        wdata             = v.wdata;
        bus.mem_rdata     = v.mrd;
        bus.mem_ack       = 1'b0;
        start             = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        addr  = ~v.addr;
        wdata = ~v.wdata;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.mem_req) begin
                chk($sformatf("v%0d mem_we", idx), {31'b0, bus.mem_we}, {31'b0, v.we});
                chk($sformatf("v%0d mem_be", idx), {28'b0, bus.mem_be}, {28'b0, v.be});
                chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr & ~32'h3);
                if (v.chk_wd)
                    chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.wd);
                bus.mem_ack = (reqs == v.dly);
                reqs++;
            end else begin
                bus.mem_ack = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                chk($sformatf("v%0d rdata_out", idx), rdata_out, v.rd);
                chk($sformatf("v%0d fault", idx), {30'b0, fault}, {30'b0, v.flt});
                chk($sformatf("v%0d latency", idx), lat, v.lat);
                chk($sformatf("v%0d req_cycles", idx), reqs, v.reqs);
            end
        end
        bus.mem_ack = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL v%0d done_wait: got no done want done within 40 cycles", idx);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        //          we    f3      addr          wdata         mrd           dly    cwd   be       wd            rd            flt    lat  reqs
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0,     1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'b00, 2,   1};
        vecs[1]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hDEAD_BEEF, 0,     1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0,        2'b00, 2,   1};
        vecs[2]  = '{1'b0, 3'b010, 32'h0000_0005, 32'h0,        32'h1111_1111, 0,     1'b0, 4'b0000, 32'h0,        32'h0,        2'b01, 1,   0};
        vecs[3]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h1234_5678, NEVER, 1'b0, 4'b1111, 32'h0,        32'h0,        2'b10, TO+1, TO};
        vecs[4]  = '{1'b0, 3'b011, 32'h0000_0008, 32'h0,        32'h1234_5678, 0,     1'b0, 4'b0000, 32'h0,        32'h0,        2'b11, 1,   0};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'hF00D_0000, 0,     1'b0, 4'b1100, 32'h0,        32'h0000_F00D, 2'b00, 2,   1};
        vecs[6]  = '{1'b0, 3'b001, 32'h0000_0006, 32'h0,        32'h8001_1234, 2,     1'b0, 4'b1100, 32'h0,        32'hFFFF_8001, 2'b00, 4,   3};
        vecs[7]  = '{1'b0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_9A00, 1,     1'b0, 4'b0010, 32'h0,        32'h0000_009A, 2'b00, 3,   2};
        vecs[8]  = '{1'b1, 3'b000, 32'h0000_0003, 32'hAABB_CC5E, 32'h5555_5555, 0,     1'b1, 4'b1000, 32'h5E5E_5E5E, 32'h0,        2'b00, 2,   1};
        vecs[9]  = '{1'b1, 3'b010, 32'h0000_000C, 32'hCAFE_F00D, 32'h5555_5555, 1,     1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0,        2'b00, 3,   2};
        vecs[10] = '{1'b1, 3'b100, 32'h0000_0000, 32'h1,        32'h0,         0,     1'b0, 4'b0000, 32'h0,        32'h0,        2'b11, 1,   0};
        vecs[11] = '{1'b1, 3'b101, 32'h0000_0001, 32'h1,        32'h0,         0,     1'b0, 4'b0000, 32'h0,        32'h0,        2'b11, 1,   0};
        vecs[12] = '{1'b1, 3'b010, 32'h0000_0002, 32'h1,        32'h0,         0,     1'b0, 4'b0000, 32'h0,        32'h0,        2'b01, 1,   0};
        vecs[13] = '{1'b0, 3'b010, 32'h0000_0044, 32'h0,        32'h89AB_CDEF, TO-1,  1'b0, 4'b1111, 32'h0,        32'h89AB_CDEF, 2'b00, TO+1, TO};
        vecs[14] = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,         0,     1'b0, 4'b0000, 32'h0,        32'h0,        2'b01, 1,   0};

        rst_n         = 1'b0;
        start         = 1'b0;
        memwrite      = 1'b0;
        funct3        = 3'b000;
        addr          = '0;
        wdata         = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", {31'b0, busy}, 32'h0);
        chk("rst done", {31'b0, done}, 32'h0);
        chk("rst mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst mem_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst mem_be", {28'b0, bus.mem_be}, 32'h0);
        chk("rst fault", {30'b0, fault}, 32'h0);
        chk("rst rdata_out", rdata_out, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during REQ: abort with no done, and a late ack must not revive the access.
        @(negedge clk);
        memwrite = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h0000_0020;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("rstreq mem_req before", {31'b0, bus.mem_req}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstreq busy", {31'b0, busy}, 32'h0);
        chk("rstreq mem_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rstreq done", {31'b0, done}, 32'h0);
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("late ack done c%0d", k), {31'b0, done}, 32'h0);
            chk($sformatf("late ack busy c%0d", k), {31'b0, busy}, 32'h0);
        end
        bus.mem_ack = 1'b0;

        // Back-to-back: start held through DONE is ignored there and taken in the next IDLE cycle.
        run_vec(vecs[5], 100);
        memwrite = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0040;
        wdata    = 32'h1122_3344;
        start    = 1'b1;
        @(negedge clk);
        chk("b2b idle busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b mem_req", {31'b0, bus.mem_req}, 32'h1);
        chk("b2b mem_addr", bus.mem_addr, 32'h0000_0040);
        chk("b2b mem_wdata", bus.mem_wdata, 32'h1122_3344);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("b2b done", {31'b0, done}, 32'h1);
        chk("b2b rdata_out", rdata_out, 32'h0);
        chk("b2b fault", {30'b0, fault}, 32'h0);
        @(negedge clk);
        chk("b2b after done", {31'b0, done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
